// File: rtl/ma_peak_detect.sv
// Threshold-gated peak detector for the averaged magnitude stream: tracks the maximum
// inside a detection window, reports it once, then holds off. Macro PEAK_HYST_EN adds exit hysteresis.
module ma_peak_detect #(
    parameter int WORD_LENGTH = 16,
    parameter int IN_WIDTH    = (WORD_LENGTH * 2 + 3) * 2 + 1,
    parameter int INDEX_WIDTH = 16,
    parameter int MAX_TRACK   = 64,
    parameter int HOLDOFF     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [IN_WIDTH-1:0]    ma_in,
    input  logic [IN_WIDTH-1:0]    threshold,
    output logic                   peak_valid,
    output logic [IN_WIDTH-1:0]    peak_value,
    output logic [INDEX_WIDTH-1:0] peak_index,
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_HOLDOFF
    } state_t;

    localparam logic [15:0] TRACK_LAST = 16'(MAX_TRACK);
    localparam logic [15:0] HOLD_LAST  = (HOLDOFF == 0) ? 16'd0 : 16'(HOLDOFF - 1);
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE = INDEX_WIDTH'(1);

    state_t                 state_reg, state_next;
    logic [INDEX_WIDTH-1:0] idx_reg;
    logic [IN_WIDTH-1:0]    max_reg, max_next;
    logic [INDEX_WIDTH-1:0] max_idx_reg, max_idx_next;
    logic [15:0]            track_cnt_reg, track_cnt_next;
    logic [15:0]            hold_cnt_reg, hold_cnt_next;
    logic                   report;
    logic                   peak_valid_reg;
    logic [IN_WIDTH-1:0]    peak_value_reg;
    logic [INDEX_WIDTH-1:0] peak_index_reg;
    logic                   busy_reg;
    logic [IN_WIDTH-1:0]    exit_level;

`ifdef PEAK_HYST_EN
    // Close the window only below 7/8 of threshold; cannot underflow since t>>3 <= t.
    assign exit_level = threshold - (threshold >> 3);
`else
    assign exit_level = threshold;
`endif

    always_comb begin
        state_next     = state_reg;
        max_next       = max_reg;
        max_idx_next   = max_idx_reg;
        track_cnt_next = track_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        report         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ma_in > threshold) begin
                    state_next     = ST_TRACK;
                    max_next       = ma_in;
                    max_idx_next   = idx_reg;
                    track_cnt_next = 16'd1;
                end
            end
            ST_TRACK: begin
                // The exiting sample is never folded into the maximum.
                if ((ma_in <= exit_level) || (track_cnt_reg == TRACK_LAST)) begin
                    report        = 1'b1;
                    hold_cnt_next = 16'd0;
                    state_next    = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                end else begin
                    if (ma_in > max_reg) begin
                        max_next     = ma_in;
                        max_idx_next = idx_reg;
                    end
                    track_cnt_next = track_cnt_reg + 16'd1;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            max_reg        <= '0;
            max_idx_reg    <= '0;
            track_cnt_reg  <= '0;
            hold_cnt_reg   <= '0;
            peak_valid_reg <= 1'b0;
            peak_value_reg <= '0;
            peak_index_reg <= '0;
            busy_reg       <= 1'b0;
        end else begin
            // The report pulse clears every clock, independent of en.
            peak_valid_reg <= 1'b0;
            if (en) begin
                state_reg     <= state_next;
                idx_reg       <= idx_reg + IDX_ONE;
                max_reg       <= max_next;
                max_idx_reg   <= max_idx_next;
                track_cnt_reg <= track_cnt_next;
                hold_cnt_reg  <= hold_cnt_next;
                busy_reg      <= (state_next != ST_IDLE);
                if (report) begin
                    peak_valid_reg <= 1'b1;
                    peak_value_reg <= max_reg;
                    peak_index_reg <= max_idx_reg;
                end
            end
        end
    end

    assign peak_valid = peak_valid_reg;
    assign peak_value = peak_value_reg;
    assign peak_index = peak_index_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_ma_peak_detect.sv
// Directed bench for ma_peak_detect: three instances (default, short cap/hold-off with
// 4-bit index, zero hold-off) exercised by one task per scenario.
module tb_ma_peak_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_s  [3];
    logic [70:0] ma_s  [3];
    logic [70:0] thr_s [3];

    logic        pv_a, pv_b, pv_c;
    logic        busy_a, busy_b, busy_c;
    logic [70:0] val_a, val_b, val_c;
    logic [15:0] idx_a, idx_c;
    logic [3:0]  idx_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ma_peak_detect dut_a (
        .clk(clk), .rst(rst), .en(en_s[0]), .ma_in(ma_s[0]), .threshold(thr_s[0]),
        .peak_valid(pv_a), .peak_value(val_a), .peak_index(idx_a), .busy(busy_a)
    );

    ma_peak_detect #(.INDEX_WIDTH(4), .MAX_TRACK(4), .HOLDOFF(3)) dut_b (
        .clk(clk), .rst(rst), .en(en_s[1]), .ma_in(ma_s[1]), .threshold(thr_s[1]),
        .peak_valid(pv_b), .peak_value(val_b), .peak_index(idx_b), .busy(busy_b)
    );

    ma_peak_detect #(.HOLDOFF(0)) dut_c (
        .clk(clk), .rst(rst), .en(en_s[2]), .ma_in(ma_s[2]), .threshold(thr_s[2]),
        .peak_valid(pv_c), .peak_value(val_c), .peak_index(idx_c), .busy(busy_c)
    );

    task automatic step(input int d, input logic e, input int v);
        en_s[d] = e;
        ma_s[d] = 71'(v);
        @(posedge clk);
        #1;
        case (d)
            0: $display("dut=a en=%0b in=%0d pv=%0b val=%0d idx=%0d busy=%0b", e, v, pv_a, val_a, idx_a, busy_a);
            1: $display("dut=b en=%0b in=%0d pv=%0b val=%0d idx=%0d busy=%0b", e, v, pv_b, val_b, idx_b, busy_b);
            default: $display("dut=c en=%0b in=%0d pv=%0b val=%0d idx=%0d busy=%0b", e, v, pv_c, val_c, idx_c, busy_c);
        endcase
        en_s[d] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pv_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", pv_a); end
        total++; if (val_a !== 71'd0) begin bad++; $display("FAIL reset_value got=%0d want=0", val_a); end
        total++; if (idx_a !== 16'd0) begin bad++; $display("FAIL reset_index got=%0d want=0", idx_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy_a); end
        total++; if (busy_b !== 1'b0 || pv_b !== 1'b0) begin bad++; $display("FAIL reset_b got=%0b%0b want=00", busy_b, pv_b); end
    endtask

    task automatic test_basic_peak();
        do_reset();
        thr_s[0] = 71'd100;
        step(0, 1'b1, 50);
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL basic_busy0 got=%0b want=0", busy_a); end
        step(0, 1'b1, 120);
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL basic_busy1 got=%0b want=1", busy_a); end
        step(0, 1'b1, 180);
        step(0, 1'b1, 150);
        total++; if (pv_a !== 1'b0) begin bad++; $display("FAIL basic_early got=%0b want=0", pv_a); end
        step(0, 1'b1, 90);
        total++; if (pv_a !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", pv_a); end
        total++; if (val_a !== 71'd180) begin bad++; $display("FAIL basic_value got=%0d want=180", val_a); end
        total++; if (idx_a !== 16'd2) begin bad++; $display("FAIL basic_index got=%0d want=2", idx_a); end
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL basic_busy_ho got=%0b want=1", busy_a); end
        step(0, 1'b1, 500);
        total++; if (pv_a !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%0b want=0", pv_a); end
        total++; if (val_a !== 71'd180) begin bad++; $display("FAIL basic_hold got=%0d want=180", val_a); end
        for (int i = 0; i < 30; i++) step(0, 1'b1, 500);
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL basic_ho31 got=%0b want=1", busy_a); end
        step(0, 1'b1, 500);
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL basic_ho32 got=%0b want=0", busy_a); end
    endtask

    task automatic test_tie_cap();
        do_reset();
        thr_s[1] = 71'd10;
        step(1, 1'b1, 20);
        step(1, 1'b1, 30);
        step(1, 1'b1, 30);
        step(1, 1'b1, 25);
        total++; if (pv_b !== 1'b0) begin bad++; $display("FAIL cap_early got=%0b want=0", pv_b); end
        step(1, 1'b1, 40);
        total++; if (pv_b !== 1'b1) begin bad++; $display("FAIL cap_valid got=%0b want=1", pv_b); end
        total++; if (val_b !== 71'd30) begin bad++; $display("FAIL cap_value got=%0d want=30", val_b); end
        total++; if (idx_b !== 4'd1) begin bad++; $display("FAIL cap_index got=%0d want=1", idx_b); end
        step(1, 1'b1, 40);
        step(1, 1'b1, 40);
        total++; if (pv_b !== 1'b0 || busy_b !== 1'b1) begin bad++; $display("FAIL cap_holdoff got=%0b%0b want=01", pv_b, busy_b); end
        step(1, 1'b1, 40);
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL cap_idle got=%0b want=0", busy_b); end
    endtask

    task automatic test_holdoff();
        do_reset();
        thr_s[1] = 71'd10;
        step(1, 1'b1, 20);
        step(1, 1'b1, 5);
        total++; if (pv_b !== 1'b1 || val_b !== 71'd20) begin bad++; $display("FAIL ho_first got=%0b/%0d want=1/20", pv_b, val_b); end
        step(1, 1'b1, 5);
        step(1, 1'b1, 50);
        total++; if (busy_b !== 1'b1 || pv_b !== 1'b0) begin bad++; $display("FAIL ho_ignore got=%0b%0b want=10", busy_b, pv_b); end
        step(1, 1'b1, 60);
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL ho_last got=%0b want=0", busy_b); end
        step(1, 1'b1, 70);
        total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL ho_reopen got=%0b want=1", busy_b); end
        step(1, 1'b1, 2);
        total++; if (pv_b !== 1'b1) begin bad++; $display("FAIL ho_second got=%0b want=1", pv_b); end
        total++; if (val_b !== 71'd70 || idx_b !== 4'd5) begin bad++; $display("FAIL ho_second_rep got=%0d@%0d want=70@5", val_b, idx_b); end
    endtask

    task automatic test_hysteresis();
        int reports = 0;
        int exp_reports;
        do_reset();
        thr_s[2] = 71'd800;
`ifdef PEAK_HYST_EN
        exp_reports = 1;
`else
        exp_reports = 2;
`endif
        step(2, 1'b1, 900);
        step(2, 1'b1, 760);
        if (pv_c === 1'b1) reports++;
`ifndef PEAK_HYST_EN
        total++; if (val_c !== 71'd900 || idx_c !== 16'd0) begin bad++; $display("FAIL hyst_first got=%0d@%0d want=900@0", val_c, idx_c); end
`endif
        step(2, 1'b1, 1000);
        if (pv_c === 1'b1) reports++;
        step(2, 1'b1, 690);
        if (pv_c === 1'b1) reports++;
        total++; if (pv_c !== 1'b1) begin bad++; $display("FAIL hyst_valid got=%0b want=1", pv_c); end
        total++; if (val_c !== 71'd1000 || idx_c !== 16'd2) begin bad++; $display("FAIL hyst_report got=%0d@%0d want=1000@2", val_c, idx_c); end
        total++; if (reports != exp_reports) begin bad++; $display("FAIL hyst_count got=%0d want=%0d", reports, exp_reports); end
        total++; if (busy_c !== 1'b0) begin bad++; $display("FAIL hyst_busy got=%0b want=0", busy_c); end
    endtask

    task automatic test_reset_mid_track();
        do_reset();
        thr_s[0] = 71'd100;
        step(0, 1'b1, 300);
        step(0, 1'b1, 10);
        total++; if (val_a !== 71'd300) begin bad++; $display("FAIL rmt_pre got=%0d want=300", val_a); end
        do_reset();
        step(0, 1'b1, 200);
        en_s[0] = 1'b1;
        ma_s[0] = 71'd500;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en_s[0] = 1'b0;
        total++; if (pv_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL rmt_flags got=%0b%0b want=00", pv_a, busy_a); end
        total++; if (val_a !== 71'd0 || idx_a !== 16'd0) begin bad++; $display("FAIL rmt_outputs got=%0d@%0d want=0@0", val_a, idx_a); end
        step(0, 1'b1, 300);
        step(0, 1'b1, 10);
        total++; if (pv_a !== 1'b1 || idx_a !== 16'd0) begin bad++; $display("FAIL rmt_next got=%0b@%0d want=1@0", pv_a, idx_a); end
    endtask

    task automatic test_en_wrap();
        int reports = 0;
        int v;
        do_reset();
        thr_s[1] = 71'd10;
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 1) begin
                step(1, 1'b0, 999);
                if (k == 39) begin
                    total++; if (pv_b !== 1'b0) begin bad++; $display("FAIL wrap_clear got=%0b want=0", pv_b); end
                end
                if (k == 35) begin
                    total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL wrap_busy got=%0b want=1", busy_b); end
                end
            end else begin
                case (k / 2)
                    16: v = 20;
                    17: v = 90;
                    18: v = 30;
                    19: v = 5;
                    default: v = 0;
                endcase
                step(1, 1'b1, v);
                if (k / 2 == 19) begin
                    total++; if (pv_b !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%0b want=1", pv_b); end
                    total++; if (val_b !== 71'd90 || idx_b !== 4'd1) begin bad++; $display("FAIL wrap_report got=%0d@%0d want=90@1", val_b, idx_b); end
                end
            end
            if (pv_b === 1'b1) reports++;
        end
        total++; if (reports != 1) begin bad++; $display("FAIL wrap_count got=%0d want=1", reports); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            en_s[i]  = 1'b0;
            ma_s[i]  = '0;
            thr_s[i] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_basic_peak();
        test_tie_cap();
        test_holdoff();
        test_hysteresis();
        test_reset_mid_track();
        test_en_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
